// File: rtl/at93c46d_pkg.sv
// Shared opcode constants and FSM state encoding for the AT93C46D responder.
package at93c46d_pkg;

    // Two-bit opcodes that follow the start bit.
    localparam logic [1:0] OP_EXT   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Extended sub-codes carried in the two address MSBs when op is OP_EXT.
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OPADDR,
        ST_READ,
        ST_WDATA,
        ST_WAIT_CS_LOW,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/at93c46d_sync_edge.sv
// Multi-stage synchronizer with a registered-history edge detector.
module at93c46d_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RISING      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync_q,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] pipe_q, pipe_d;
    logic                   prev_q, prev_d;

    // Shift the raw pin in and remember last synchronized level.
    always_comb begin
        pipe_d = (pipe_q << 1) | SYNC_STAGES'(d);
        prev_d = pipe_q[SYNC_STAGES-1];
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
            prev_q <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            prev_q <= prev_d;
        end
    end

    assign sync_q = pipe_q[SYNC_STAGES-1];
    assign edge_c = RISING ? (sync_q & ~prev_q) : (~sync_q & prev_q);

endmodule

// File: rtl/at93c46d_responder.sv
// Microwire slave emulating an AT93C46D (x16, 64 words) with self-timed programming.
module at93c46d_responder
    import at93c46d_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned T_WP_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic din,
    output logic dout,
    output logic busy,
    output logic ew_en
);

    localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned CMD_W = 2 + ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned WP_W  = $clog2(T_WP_CYCLES + 1);

    logic sclk_s, sclk_rise_c;
    logic cs_s, cs_fall_c;
    logic din_s;

    logic [SYNC_STAGES-1:0] din_pipe_q, din_pipe_d;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic                  dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  ew_en_q, ew_en_d;
    logic [WP_W-1:0]       wp_q, wp_d;
    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] mem_d [WORDS];

    logic [DATA_WIDTH-1:0] shift_in_c;
    logic [CMD_W-1:0]      cmd_c;
    logic [ADDR_WIDTH-1:0] addr_next_c;

    at93c46d_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b1)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sclk),
        .sync_q (sclk_s),
        .edge_c (sclk_rise_c)
    );

    at93c46d_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b0)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (cs),
        .sync_q (cs_s),
        .edge_c (cs_fall_c)
    );

    // Data pin needs the same latency as sclk so it lines up with the rise.
    always_comb begin
        din_pipe_d = (din_pipe_q << 1) | SYNC_STAGES'(din);
    end

    assign din_s = din_pipe_q[SYNC_STAGES-1];

    // Command decode, shifting, commit and programming timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        op_d    = op_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        ew_en_d = ew_en_q;
        wp_d    = wp_q;
        mem_d   = mem_q;

        shift_in_c  = {sh_q[DATA_WIDTH-2:0], din_s};
        cmd_c       = shift_in_c[CMD_W-1:0];
        addr_next_c = addr_q + ADDR_WIDTH'(1);

        if (busy_q) begin
            if (wp_q == WP_W'(1)) begin
                busy_d = 1'b0;
                wp_d   = '0;
            end else begin
                wp_d = wp_q - WP_W'(1);
            end
        end

        if (!cs_s && (state_q != ST_WAIT_CS_LOW)) begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_s) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    dout_d = ~busy_q;
                    if (sclk_rise_c && din_s && !busy_q) begin
                        state_d = ST_OPADDR;
                        cnt_d   = '0;
                    end
                end
                ST_OPADDR: begin
                    if (sclk_rise_c) begin
                        sh_d  = shift_in_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CMD_W - 1)) begin
                            op_d   = cmd_c[CMD_W-1 -: 2];
                            addr_d = cmd_c[ADDR_WIDTH-1:0];
                            cnt_d  = '0;
                            case (cmd_c[CMD_W-1 -: 2])
                                OP_READ: begin
                                    dout_d  = 1'b0;
                                    sh_d    = mem_q[cmd_c[ADDR_WIDTH-1:0]];
                                    state_d = ST_READ;
                                end
                                OP_WRITE: state_d = ST_WDATA;
                                OP_ERASE: state_d = ST_WAIT_CS_LOW;
                                default: begin
                                    case (cmd_c[ADDR_WIDTH-1 -: 2])
                                        EXT_EWEN: begin
                                            ew_en_d = 1'b1;
                                            state_d = ST_IGNORE;
                                        end
                                        EXT_EWDS: begin
                                            ew_en_d = 1'b0;
                                            state_d = ST_IGNORE;
                                        end
                                        EXT_ERAL: state_d = ST_WAIT_CS_LOW;
                                        default:  state_d = ST_WDATA;
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_rise_c) begin
                        dout_d = sh_q[DATA_WIDTH-1];
                        sh_d   = {sh_q[DATA_WIDTH-2:0], 1'b0};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            addr_d = addr_next_c;
                            sh_d   = mem_q[addr_next_c];
                            cnt_d  = '0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise_c) begin
                        sh_d  = shift_in_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_WAIT_CS_LOW;
                        end
                    end
                end
                ST_WAIT_CS_LOW: begin
                    if (cs_fall_c) begin
                        state_d = ST_IDLE;
                        dout_d  = 1'b0;
                        if (ew_en_q) begin
                            busy_d = 1'b1;
                            wp_d   = WP_W'(T_WP_CYCLES);
                            case (op_q)
                                OP_WRITE: mem_d[addr_q] = sh_q;
                                OP_ERASE: mem_d[addr_q] = '1;
                                default: begin
                                    for (int i = 0; i < WORDS; i++) begin
                                        mem_d[i] = (addr_q[ADDR_WIDTH-1 -: 2] == EXT_ERAL) ? '1 : sh_q;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and memory registers; memory resets to the erased value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_pipe_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            ew_en_q    <= 1'b0;
            wp_q       <= '0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '1;
            end
        end else begin
            din_pipe_q <= din_pipe_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            ew_en_q    <= ew_en_d;
            wp_q       <= wp_d;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout  = dout_q;
    assign busy  = busy_q;
    assign ew_en = ew_en_q;

    // sclk level itself is only needed for edge detection.
    logic unused_c;
    assign unused_c = sclk_s;

endmodule

// File: tb/tb_at93c46d_responder.sv
// Directed bench for the AT93C46D responder acting as a Microwire master.
module tb_at93c46d_responder;

    logic clk = 1'b0;
    logic rst, cs, sclk, din;
    logic dout, busy, ew_en;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_words [64];

    at93c46d_responder dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .sclk  (sclk),
        .din   (din),
        .dout  (dout),
        .busy  (busy),
        .ew_en (ew_en)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period: sample dout just before the rise, then pulse sclk.
    task automatic bit_x(input logic b, output logic o);
        din = b;
        clks(8);
        o = dout;
        sclk = 1'b1;
        clks(8);
        sclk = 1'b0;
    endtask

    task automatic cs_hi();
        cs = 1'b1;
        clks(8);
    endtask

    task automatic cs_lo();
        clks(8);
        cs = 1'b0;
        clks(8);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic o;
        bit_x(1'b1, o);
        for (int i = 7; i >= 0; i--) bit_x(c[i], o);
    endtask

    // Full command frame with optional data bits, leaving cs high.
    task automatic frame(input logic [7:0] c, input logic [15:0] d, input int nbits);
        logic o;
        cs_hi();
        send_cmd(c);
        for (int i = 15; i > 15 - nbits; i--) bit_x(d[i], o);
    endtask

    task automatic read_words(input logic [7:0] c, input int n, output logic dmy);
        logic o;
        logic [15:0] w;
        cs_hi();
        send_cmd(c);
        bit_x(1'b0, dmy);
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int b = 0; b < 16; b++) begin
                bit_x(1'b0, o);
                w = {w[14:0], o};
            end
            rd_words[k] = w;
        end
        cs_lo();
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            clks(1);
            k++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    task automatic count_bad(input int n, input logic [15:0] exp, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) if (rd_words[i] !== exp) bad++;
    endtask

    initial begin
        logic dmy;
        logic st;
        int   n;
        int   bad;

        rst = 1'b1; cs = 1'b0; sclk = 1'b0; din = 1'b0;
        clks(3);
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ewen", 32'(ew_en), 32'(0));
        rst = 1'b0;
        clks(4);

        // Erased word read after reset.
        read_words(8'hB5, 1, dmy);
        chk("read_dummy", 32'(dmy), 32'(0));
        chk("read_erased", 32'(rd_words[0]), 32'hFFFF);
        chk("read_busy", 32'(busy), 32'(0));
        chk("read_ewen", 32'(ew_en), 32'(0));

        // WRITE without EWEN must not program.
        frame(8'h75, 16'hE801, 16);
        cs_lo();
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            clks(1);
            if (busy) n++;
        end
        chk("wr_noewen_busy", 32'(n), 32'(0));
        read_words(8'hB5, 1, dmy);
        chk("wr_noewen_data", 32'(rd_words[0]), 32'hFFFF);

        // EWEN then WRITE with precise busy timing and status polling.
        frame(8'h30, 16'h0, 0);
        cs_lo();
        chk("ewen_set", 32'(ew_en), 32'(1));
        frame(8'h75, 16'hE801, 16);
        clks(8);
        cs = 1'b0;
        n = 0;
        while (!busy && n < 50) begin
            clks(1);
            n++;
        end
        chk("busy_rise", 32'(busy), 32'(1));
        n = 0;
        st = 1'bx;
        while (busy && n < 2000) begin
            clks(1);
            n++;
            if (n == 20) cs = 1'b1;
            if (n == 40) st = dout;
        end
        chk("busy_len", 32'(n), 32'(1000));
        chk("status_busy", 32'(st), 32'(0));
        clks(8);
        chk("status_ready", 32'(dout), 32'(1));
        cs_lo();
        read_words(8'hB5, 1, dmy);
        chk("wr_data", 32'(rd_words[0]), 32'hE801);

        // Sequential read wraps from 0x3F to 0x00.
        frame(8'h7F, 16'h1234, 16);
        cs_lo();
        wait_ready("wr3f_ready");
        frame(8'h40, 16'hABCD, 16);
        cs_lo();
        wait_ready("wr00_ready");
        read_words(8'hBF, 2, dmy);
        chk("wrap_w0", 32'(rd_words[0]), 32'h1234);
        chk("wrap_w1", 32'(rd_words[1]), 32'hABCD);

        // Truncated write never commits.
        frame(8'h75, 16'h0000, 8);
        cs_lo();
        clks(20);
        chk("trunc_busy", 32'(busy), 32'(0));
        read_words(8'hB5, 1, dmy);
        chk("trunc_data", 32'(rd_words[0]), 32'hE801);

        // EWDS then ERAL is rejected.
        frame(8'h00, 16'h0, 0);
        cs_lo();
        chk("ewds_clr", 32'(ew_en), 32'(0));
        frame(8'h20, 16'h0, 0);
        cs_lo();
        clks(20);
        chk("eral_busy", 32'(busy), 32'(0));
        read_words(8'hBF, 2, dmy);
        chk("eral_w3f", 32'(rd_words[0]), 32'h1234);
        chk("eral_w00", 32'(rd_words[1]), 32'hABCD);

        // WRAL fills every word.
        frame(8'h30, 16'h0, 0);
        cs_lo();
        frame(8'h10, 16'h5A5A, 16);
        cs_lo();
        chk("wral_busy", 32'(busy), 32'(1));
        wait_ready("wral_ready");
        read_words(8'h80, 64, dmy);
        count_bad(64, 16'h5A5A, bad);
        chk("wral_all", 32'(bad), 32'(0));

        // Reset during programming restores everything.
        frame(8'h10, 16'h1111, 16);
        cs_lo();
        chk("wral2_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        clks(2);
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_ewen", 32'(ew_en), 32'(0));
        chk("mid_rst_dout", 32'(dout), 32'(0));
        rst = 1'b0;
        clks(4);
        read_words(8'h80, 64, dmy);
        count_bad(64, 16'hFFFF, bad);
        chk("mid_rst_mem", 32'(bad), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
